// File: rtl/dst_pingpong_buf.sv
// rtl/dst_pingpong_buf.sv - two-bank ping-pong destination buffer draining to a valid/ready stream
// One bank is written by the sample controller while the other drains; banks hand off via wr_done.
module dst_pingpong_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              outr,
   input  logic [ADDR_W-1:0] oa,
   input  logic [DATA_W-1:0] x,
   input  logic              wr_done,
   input  logic [CNT_W-1:0]  wr_len,
   input  logic              wr_last,
   output logic              wr_ready,
   output logic              dst_valid,
   output logic [DATA_W-1:0] dst_data,
   output logic              dst_last,
   input  logic              dst_ready,
   output logic              busy
);
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

   typedef enum logic {IDLE, DRAIN} rstate_t;
   rstate_t state, state_nx;

   logic [DATA_W-1:0] mem [0:2*(2**ADDR_W)-1];
   logic [1:0]        full;
   logic [1:0]        lastf;
   logic [CNT_W-1:0]  len [0:1];
   logic              wsel, rsel;
   logic [CNT_W-1:0]  rcnt;
   logic              wr_done_ignored;

   logic             accept, issue, last_rd, zero_rel, chain;
   logic [CNT_W-1:0] cur_len, oth_len;

   assign cur_len   = len[rsel];
   assign oth_len   = len[~rsel];
   assign wr_ready  = ~full[wsel];
   assign busy      = (|full) | dst_valid;
   assign accept    = wr_done & wr_ready;
   assign issue     = (state == DRAIN) & (~dst_valid | dst_ready);
   assign last_rd   = issue & (rcnt == cur_len - CNT_W'(1));
   assign zero_rel  = (state == IDLE) & full[rsel] & (cur_len == '0);
   // Chaining straight into an already-full next bank avoids a bubble at the bank switch.
   assign chain     = last_rd & full[~rsel] & (oth_len != '0);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (full[rsel] && cur_len != '0) state_nx = DRAIN;
         DRAIN:   if (last_rd && !chain) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (outr) mem[{wsel, oa}] <= x;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full            <= '0;
         lastf           <= '0;
         len[0]          <= '0;
         len[1]          <= '0;
         wsel            <= 1'b0;
         rsel            <= 1'b0;
         rcnt            <= '0;
         dst_valid       <= 1'b0;
         dst_data        <= '0;
         dst_last        <= 1'b0;
         wr_done_ignored <= 1'b0;
      end else begin
         wr_done_ignored <= wr_done & ~wr_ready;
         if (accept) begin
            full[wsel]  <= 1'b1;
            len[wsel]   <= (wr_len > DEPTH) ? DEPTH : wr_len;
            lastf[wsel] <= wr_last;
            wsel        <= ~wsel;
         end
         // accept needs full[wsel]=0 and release needs full[rsel]=1, so they never hit the same bank.
         if (last_rd || zero_rel) begin
            full[rsel] <= 1'b0;
            rsel       <= ~rsel;
         end
         if (issue) begin
            rcnt      <= last_rd ? '0 : rcnt + CNT_W'(1);
            dst_valid <= 1'b1;
            dst_data  <= mem[{rsel, rcnt[ADDR_W-1:0]}];
            dst_last  <= lastf[rsel] & (rcnt == cur_len - CNT_W'(1));
         end else if (dst_ready) begin
            dst_valid <= 1'b0;
            dst_last  <= 1'b0;
         end
      end
   end
endmodule
